// File: rtl/mem_read_responder.sv
// Memory-side read responder: level-held request, programmable wait states,
// registered data_ready/data_bus hold window, preloadable RAM and read counter.
module mem_read_responder #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] addr,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_bus,
    output logic              data_ready,
    output logic              busy,
    output logic [7:0]        read_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int MAXC  = (WAIT_CYCLES > HOLD_CYCLES) ? WAIT_CYCLES : HOLD_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);
    localparam logic [CW-1:0] WLAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] HLAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY,
        S_RELEASE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [ADDR_W-1:0]   lat_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                enter_ready;
    logic [DATA_W-1:0]   ram [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                // a write in the same cycle defers the read by one edge
                if (mem_read && !mem_write)
                    state_nxt = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
            end
            S_WAIT: begin
                if (!mem_read)         state_nxt = S_IDLE;
                else if (cnt == WLAST) state_nxt = S_READY;
            end
            S_READY: begin
                if (!mem_read)         state_nxt = S_IDLE;
                else if (cnt == HLAST) state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!mem_read) state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy        = (state != S_IDLE);
        enter_ready = (state_nxt == S_READY) && (state != S_READY);
        rd_addr     = (state == S_IDLE) ? addr : lat_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            lat_addr   <= '0;
            data_bus   <= '0;
            data_ready <= 1'b0;
            read_count <= '0;
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else begin
            if (state_nxt != state)
                cnt <= '0;
            else if (state == S_WAIT || state == S_READY)
                cnt <= cnt + 1'b1;
            if (state == S_IDLE && state_nxt != S_IDLE)
                lat_addr <= addr;
            if (state == S_IDLE && mem_write)
                ram[addr] <= wr_data;
            data_ready <= (state_nxt == S_READY);
            if (enter_ready)
                data_bus <= ram[rd_addr];
            else if (state_nxt != S_READY)
                data_bus <= '0;
            if (enter_ready && read_count != 8'hFF)
                read_count <= read_count + 8'd1;
        end
    end
endmodule

// File: doc/mem_read_responder.md
Name: mem_read_responder

Overview:
Memory-side partner of the level-wait read requester. It samples a level-held mem_read request, inserts a programmable number of wait states, then drives data_bus and asserts data_ready until the requester releases. It holds a small synchronous RAM with a write port so benches and upstream logic can preload contents. It also keeps a saturating count of completed reads for debug.

Parameters:
ADDR_W, 4, address width; RAM depth is 2**ADDR_W.
DATA_W, 8, data width of RAM, wr_data and data_bus.
WAIT_CYCLES, 3, wait states between request accept and data_ready; 0 is legal.
HOLD_CYCLES, 2, cycles data_ready stays high (>=1).

Ports:
clk  input  1  single clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
mem_read  input  1  level read request, held high by requester until it has the data.
addr  input  ADDR_W  read/write address; sampled at accept.
mem_write  input  1  write strobe, one word per cycle.
wr_data  input  DATA_W  write data.
data_bus  output  DATA_W  read data; valid only while data_ready=1, else 0.
data_ready  output  1  read data valid (registered).
busy  output  1  high whenever state != IDLE.
read_count  output  8  completed reads, saturates at 255.

Behaviour:
- Reset (sampled rst=1 at an edge): state=IDLE, data_ready=0, data_bus=0, busy=0, read_count=0, wait counter=0, all RAM words=0. Reset mid-transaction aborts it with no data_ready pulse.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, WAIT, READY, RELEASE.
- IDLE:
  - mem_write=1: RAM[addr]<=wr_data. Write wins over a simultaneous mem_read; the read is accepted at the next edge if mem_read is still high.
  - mem_read=1 and mem_write=0 (accept edge E0): latch addr. Go to WAIT with cnt=0, or directly to READY if WAIT_CYCLES=0.
- WAIT:
  - mem_read=0: abort to IDLE, no data_ready, read_count unchanged.
  - Otherwise cnt++ each edge. At the edge where cnt==WAIT_CYCLES-1, go to READY.
  - data_ready first high after edge E0+WAIT_CYCLES.
- READY:
  - data_bus=RAM[latched addr], data_ready=1 for HOLD_CYCLES cycles.
  - RAM read uses the value current at READY entry.
  - read_count increments once on READY entry.
  - After HOLD_CYCLES, data_ready=0, data_bus=0, go to RELEASE.
  - mem_read=0 during READY: drop data_ready and go to IDLE next edge. The read still counts.
- RELEASE: stay until mem_read=0, then IDLE. Prevents a held request from being served twice.
- mem_write outside IDLE is ignored (no RAM update).
- addr changes after accept have no effect on the read in flight.
- read_count holds at 255; no wrap.

Test Plan:
- Reset then idle, mem_read=0 for 10 cycles -> data_ready=0, data_bus=0, busy=0, read_count=0.
- Write RAM[3]=8'hDE; raise mem_read with addr=3 and hold -> data_ready rises 3 edges after accept, data_bus=8'hDE for 2 cycles. Then data_ready=0, busy=1 until mem_read drops, read_count=1.
- Drop mem_read after 1 cycle in WAIT -> no data_ready pulse, busy=0 next cycle, read_count unchanged.
- mem_write (addr=5, 8'hAD) and mem_read (addr=5) asserted in the same IDLE cycle, mem_read held -> write lands first, read returns 8'hAD one cycle later than the normal latency.
- WAIT_CYCLES=0 build, read addr=0 after reset -> data_ready high after accept edge, data_bus=8'h00. Change addr during READY -> data_bus unchanged.
- Assert rst during READY -> next cycle data_ready=0, data_bus=0, busy=0, read_count=0, RAM contents 0. 256 back-to-back reads -> read_count stays at 255.
